// File: rtl/rsa_exp_pkg.sv
// Shared types and defaults for the RSA exponent FIFO read path.
// Holds the reader FSM state type and the counter width helpers.
package rsa_exp_pkg;

    localparam int unsigned EXP_WORD_W_DEF    = 32;
    localparam int unsigned EXP_NUM_WORDS_DEF = 64;

    // word_cnt counts down from NUM_WORDS to 0 inclusive, so it needs one extra code
    function automatic int unsigned exp_wcnt_w(input int unsigned num_words);
        return $clog2(num_words + 1);
    endfunction

    localparam int unsigned EXP_WCNT_W_DEF = exp_wcnt_w(EXP_NUM_WORDS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } exp_rd_state_t;

endpackage : rsa_exp_pkg

// File: rtl/exp_bit_sreg.sv
// WORD_W-bit load/shift-left register with a bit down-counter.
// o_last flags the bit position that is the word's LSB.
module exp_bit_sreg
    import rsa_exp_pkg::*;
#(
    parameter int unsigned WORD_W = EXP_WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_shift,
    output logic              o_msb,
    output logic              o_last
);

    localparam int unsigned       CNT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
            r_cnt  <= CNT_TOP;
        end else if (i_shift) begin
            r_sreg <= r_sreg << 1;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_msb  = r_sreg[WORD_W-1];
    assign o_last = (r_cnt == '0);

endmodule : exp_bit_sreg

// File: rtl/exp_fifo_reader.sv
// Exponent FIFO read controller: pops words MSB-word first and streams bits MSB-first.
// Optional macro EXP_SKIP_LZ_EN suppresses the exponent's leading zeros.
module exp_fifo_reader
    import rsa_exp_pkg::*;
#(
    parameter int unsigned WORD_W    = EXP_WORD_W_DEF,
    parameter int unsigned NUM_WORDS = EXP_NUM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      WCNT_W   = exp_wcnt_w(NUM_WORDS);
    localparam logic [WCNT_W-1:0] WCNT_TOP = WCNT_W'(NUM_WORDS);

    exp_rd_state_t     r_state;
    logic [WCNT_W-1:0] r_word_cnt;

    logic w_msb;
    logic w_word_last;
    logic w_in_shift;
    logic w_final;
    logic w_emit;
    logic w_valid;
    logic w_hs;
    logic w_adv;
    logic w_load;

`ifdef EXP_SKIP_LZ_EN
    logic r_seen_one;
    // The final bit of the scan is always emitted so an all-zero exponent still yields one bit
    assign w_emit = r_seen_one || w_msb || w_final;
`else
    assign w_emit = 1'b1;
`endif

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_final    = w_in_shift && w_word_last && (r_word_cnt == '0);
    assign w_valid    = w_in_shift && w_emit;
    assign w_hs       = w_valid && bit_ready;
    assign w_adv      = w_hs || (w_in_shift && !w_emit);
    assign w_load     = (r_state == ST_WAIT);

    exp_bit_sreg #(
        .WORD_W (WORD_W)
    ) u_sreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (fifo_dout),
        .i_shift (w_adv),
        .o_msb   (w_msb),
        .o_last  (w_word_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
`ifdef EXP_SKIP_LZ_EN
            r_seen_one <= 1'b0;
`endif
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word_cnt <= WCNT_TOP;
                        r_state    <= ST_FETCH;
`ifdef EXP_SKIP_LZ_EN
                        r_seen_one <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_word_cnt <= r_word_cnt - 1'b1;
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
`ifdef EXP_SKIP_LZ_EN
                    if (w_hs && w_msb) begin
                        r_seen_one <= 1'b1;
                    end
`endif
                    if (w_adv && w_word_last) begin
                        r_state <= (r_word_cnt == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = (r_state == ST_FETCH) && !fifo_empty;
    assign bit_valid  = w_valid;
    assign bit_out    = w_valid && w_msb;
    assign bit_last   = w_valid && w_final;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

endmodule : exp_fifo_reader

// File: tb/tb_exp_fifo_reader.sv
// Directed bench for exp_fifo_reader with WORD_W=8, NUM_WORDS=2 and a queue-backed FIFO model.
// Leading-zero expectations follow EXP_SKIP_LZ_EN.
module tb_exp_fifo_reader;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start      = 1'b0;
    logic       abort      = 1'b0;
    logic [7:0] fifo_dout  = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready  = 1'b0;
    logic       bit_last;
    logic       busy;
    logic       done;

    logic [7:0] fq[$];

    int n_cmp = 0;
    int n_err = 0;

    int          g_n, g_last_idx, g_last_cnt, g_done_cnt, g_done_dly, g_gap;
    int          g_first_rd, g_first_val, g_rd_bad, g_unstable, g_stalls;
    logic [31:0] g_bits;
    bit          g_aborted;

    exp_fifo_reader #(
        .WORD_W    (8),
        .NUM_WORDS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_last   (bit_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO: one-cycle read latency, empty flag registered
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input int ready_mode, input int abort_at, input int restart_at,
                            input int push_at, input logic [7:0] w0, input logic [7:0] w1,
                            input int maxcyc);
        int   last_hs;
        int   cur_gap;
        logic prev_stall;
        logic prev_out;
        g_n = 0; g_last_idx = -1; g_last_cnt = 0; g_done_cnt = 0; g_done_dly = -1;
        g_gap = 0; g_first_rd = -1; g_first_val = -1; g_rd_bad = 0; g_unstable = 0;
        g_stalls = 0; g_bits = '0; g_aborted = 1'b0;
        last_hs = -1; cur_gap = 0; prev_stall = 1'b0; prev_out = 1'b0;
        for (int c = 0; c < maxcyc; c++) begin
            @(negedge clk);
            if (c == push_at) begin
                fq.push_back(w0);
                fq.push_back(w1);
            end
            start     = (c == 0) || (c == restart_at);
            abort     = 1'b0;
            bit_ready = (ready_mode == 0) ? 1'b1 : ((c % 2) == 0);
            #1;
            if (fifo_rd_en && fifo_empty) g_rd_bad++;
            if (fifo_rd_en && g_first_rd < 0) g_first_rd = c;
            if (bit_valid && g_first_val < 0) g_first_val = c;
            if (prev_stall && (!bit_valid || bit_out !== prev_out)) g_unstable++;
            prev_stall = bit_valid && !bit_ready;
            prev_out   = bit_out;
            if (prev_stall) g_stalls++;
            if (done) begin
                g_done_cnt++;
                g_done_dly = c - last_hs;
                break;
            end
            if (bit_valid && bit_ready) begin
                if (cur_gap > g_gap) g_gap = cur_gap;
                cur_gap = 0;
                g_bits  = {g_bits[30:0], bit_out};
                if (bit_last) begin
                    g_last_idx = g_n;
                    g_last_cnt++;
                end
                g_n++;
                last_hs = c;
                if (g_n == abort_at) begin
                    abort     = 1'b1;
                    g_aborted = 1'b1;
                    break;
                end
            end else if (!bit_valid && g_n > 0) begin
                cur_gap++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
    endtask

    task automatic flush_fifo();
        @(negedge clk);
        fq.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int done_seen;
        #2;
        check_eq("rst_busy",  {31'd0, busy},       32'd0);
        check_eq("rst_valid", {31'd0, bit_valid},  32'd0);
        check_eq("rst_done",  {31'd0, done},       32'd0);
        check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("rst_out",   {30'd0, bit_out, bit_last}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-rate scan of 0xA5, 0x3C
        run_scan(0, -1, -1, 0, 8'hA5, 8'h3C, 60);
        check_eq("s1_bits",     g_bits,               32'h0000A53C);
        check_eq("s1_count",    32'(g_n),             32'd16);
        check_eq("s1_last_idx", 32'(g_last_idx),      32'd15);
        check_eq("s1_last_cnt", 32'(g_last_cnt),      32'd1);
        check_eq("s1_done",     32'(g_done_cnt),      32'd1);
        check_eq("s1_done_dly", 32'(g_done_dly),      32'd1);
        check_eq("s1_gap",      32'(g_gap),           32'd2);
        check_eq("s1_first_rd", 32'(g_first_rd),      32'd1);
        check_eq("s1_first_vl", 32'(g_first_val),     32'd3);
        check_eq("s1_done_1cy", {31'd0, done},        32'd0);
        check_eq("s1_idle",     {31'd0, busy},        32'd0);

        // Backpressure: ready toggles every cycle
        run_scan(1, -1, -1, 0, 8'hA5, 8'h3C, 100);
        check_eq("s2_bits",     g_bits,               32'h0000A53C);
        check_eq("s2_count",    32'(g_n),             32'd16);
        check_eq("s2_unstable", 32'(g_unstable),      32'd0);
        check_eq("s2_stalled",  32'(g_stalls > 0),    32'd1);
        check_eq("s2_last_idx", 32'(g_last_idx),      32'd15);
        check_eq("s2_done",     32'(g_done_cnt),      32'd1);

        // FIFO empty for the first cycles after start
        run_scan(0, -1, -1, 5, 8'hFF, 8'h01, 80);
        check_eq("s3_rd_bad",   32'(g_rd_bad),        32'd0);
        check_eq("s3_first_rd", 32'(g_first_rd),      32'd6);
        check_eq("s3_rd2val",   32'(g_first_val - g_first_rd), 32'd2);
        check_eq("s3_bits",     g_bits,               32'h0000FF01);
        check_eq("s3_count",    32'(g_n),             32'd16);
        check_eq("s3_done",     32'(g_done_cnt),      32'd1);

        // Abort on the third accepted bit
        run_scan(0, 3, -1, 0, 8'hA5, 8'h3C, 60);
        check_eq("s4_aborted",  {31'd0, g_aborted},   32'd1);
        check_eq("s4_bits",     g_bits,               32'h00000005);
        check_eq("s4_busy",     {31'd0, busy},        32'd0);
        check_eq("s4_valid",    {31'd0, bit_valid},   32'd0);
        check_eq("s4_rd_en",    {31'd0, fifo_rd_en},  32'd0);
        done_seen = (g_done_cnt != 0) || done;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done || busy) done_seen = 1;
        end
        check_eq("s4_no_done",  32'(done_seen),       32'd0);
        flush_fifo();
        run_scan(0, -1, -1, 0, 8'h80, 8'h00, 60);
        check_eq("s4_re_bits",  g_bits,               32'h00008000);
        check_eq("s4_re_count", 32'(g_n),             32'd16);
        check_eq("s4_re_done",  32'(g_done_cnt),      32'd1);

        // Leading zeros
        run_scan(0, -1, -1, 0, 8'h00, 8'h05, 60);
`ifdef EXP_SKIP_LZ_EN
        check_eq("s5_bits",     g_bits,               32'h00000005);
        check_eq("s5_count",    32'(g_n),             32'd3);
        check_eq("s5_last_idx", 32'(g_last_idx),      32'd2);
`else
        check_eq("s5_bits",     g_bits,               32'h00000005);
        check_eq("s5_count",    32'(g_n),             32'd16);
        check_eq("s5_last_idx", 32'(g_last_idx),      32'd15);
`endif
        check_eq("s5_done",     32'(g_done_cnt),      32'd1);
        run_scan(0, -1, -1, 0, 8'h00, 8'h00, 60);
`ifdef EXP_SKIP_LZ_EN
        check_eq("s5z_count",   32'(g_n),             32'd1);
        check_eq("s5z_last",    32'(g_last_idx),      32'd0);
`else
        check_eq("s5z_count",   32'(g_n),             32'd16);
        check_eq("s5z_last",    32'(g_last_idx),      32'd15);
`endif
        check_eq("s5z_bits",    g_bits,               32'h00000000);
        check_eq("s5z_done",    32'(g_done_cnt),      32'd1);

        // start re-pulsed during the inter-word WAIT and ignored
        run_scan(0, -1, 12, 0, 8'hA5, 8'h3C, 60);
        check_eq("s6_bits",     g_bits,               32'h0000A53C);
        check_eq("s6_count",    32'(g_n),             32'd16);
        check_eq("s6_done",     32'(g_done_cnt),      32'd1);
        run_scan(0, -1, 5, 0, 8'hA5, 8'h3C, 60);
        check_eq("s6b_bits",    g_bits,               32'h0000A53C);
        check_eq("s6b_done",    32'(g_done_cnt),      32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_exp_fifo_reader
